// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU receive path: frame types, error bits,
// opcodes, FSM state encodings and the packet CRC4.
package alu_pkg;

  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;

  typedef logic [2:0] err_t;
  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_STOP_CHK, RX_BREAK} rx_state_t;
  typedef enum logic {PKT_COLLECT, PKT_EVAL} pkt_state_t;

  // Polynomial x^4+x+1, init 0, MSB first; result equals msg*x^4 mod p.
  function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ msg[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Serial frame receiver: start detection, bit timing, stop check and
// line-break recovery for 11-bit frames {start, type, d7..d0, stop}.
module alu_frame_rx
  import alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin_i,
  output logic       frame_valid_o,
  output logic       frame_type_o,
  output logic [7:0] frame_byte_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  localparam logic [3:0] LAST_TICK = 4'(CLKS_PER_BIT - 1);

  rx_state_t   state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  shift_q, shift_d;
  logic        armed_q, armed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  // armed_q keeps a line held low across reset release from looking like a start bit.
  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    armed_d       = armed_q | sin_i;
    frame_valid_o = 1'b0;
    frame_err_o   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (armed_q && !sin_i) begin
          state_d = RX_SHIFT;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      RX_SHIFT: begin
        if (tick_q == LAST_TICK) begin
          tick_d  = '0;
          shift_d = {shift_q[8:0], sin_i};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 4'd9) state_d = RX_STOP_CHK;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_STOP_CHK: begin
        if (shift_q[0]) begin
          frame_valid_o = 1'b1;
          state_d       = RX_IDLE;
        end else begin
          frame_err_o = 1'b1;
          state_d     = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (sin_i) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign frame_type_o = shift_q[9];
  assign frame_byte_o = shift_q[8:1];
  assign idle_o       = (state_q == RX_IDLE);

endmodule

// File: rtl/alu_sin_decoder.sv
// Receive-side front end of the serial ALU: assembles data/command frames into
// one operation packet, validates it and hands A/B/op to the core via valid/ready.
module alu_sin_decoder
  import alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun,
  output logic        busy
);

  localparam int CNT_W = $clog2(DATA_FRAMES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

  logic       frame_valid, frame_type, frame_err, rx_idle;
  logic [7:0] frame_byte;

  alu_frame_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .sin_i         (sin),
    .frame_valid_o (frame_valid),
    .frame_type_o  (frame_type),
    .frame_byte_o  (frame_byte),
    .frame_err_o   (frame_err),
    .idle_o        (rx_idle)
  );

  pkt_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       crc_q, crc_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_a_q, out_a_d, out_b_q, out_b_d;
  logic [2:0]       out_op_q, out_op_d;
  err_t             out_err_q, out_err_d;
  logic             overrun_q, overrun_d;

  logic             load;
  logic [31:0]      ld_a, ld_b;
  logic [2:0]       ld_op;
  err_t             ld_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PKT_COLLECT;
      count_q     <= '0;
      data_q      <= '0;
      op_q        <= '0;
      crc_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      data_q      <= data_d;
      op_q        <= op_d;
      crc_q       <= crc_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    data_d      = data_q;
    op_d        = op_q;
    crc_d       = crc_q;
    out_valid_d = out_valid_q && !out_ready;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    overrun_d   = overrun_q;
    load        = 1'b0;
    ld_a        = '0;
    ld_b        = '0;
    ld_op       = '0;
    ld_err      = '0;
    case (state_q)
      PKT_COLLECT: begin
        if (frame_err) begin
          load                 = 1'b1;
          ld_err[ERR_DATA_BIT] = 1'b1;
          count_d              = '0;
          data_d               = '0;
        end else if (frame_valid) begin
          if (frame_type == DATA_TYPE) begin
            data_d = {data_q[55:0], frame_byte};
            if (count_q != CNT_SAT) count_d = count_q + 1'b1;
          end else if (count_q != '0) begin
            // A command with no data before it is trailing filler and is dropped.
            op_d    = frame_byte[6:4];
            crc_d   = frame_byte[3:0];
            state_d = PKT_EVAL;
          end
        end
      end
      PKT_EVAL: begin
        load  = 1'b1;
        ld_op = op_q;
        if (count_q != CNT_FULL) begin
          ld_err[ERR_DATA_BIT] = 1'b1;
        end else begin
          ld_b = data_q[63:32];
          ld_a = data_q[31:0];
          if (crc4_calc({data_q, 1'b1, op_q}) != crc_q) ld_err[ERR_CRC_BIT] = 1'b1;
          else if (op_q[1])                            ld_err[ERR_OP_BIT]  = 1'b1;
        end
        count_d = '0;
        data_d  = '0;
        state_d = PKT_COLLECT;
      end
      default: state_d = PKT_COLLECT;
    endcase
    // An acceptance in the same cycle frees the output stage, so that is not an overrun.
    if (load) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_a_d     = ld_a;
        out_b_d     = ld_b;
        out_op_d    = ld_op;
        out_err_d   = ld_err;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;
  assign busy      = (count_q != '0) || !rx_idle;

endmodule

// File: tb/tb_alu_sin_decoder.sv
// Self-checking bench for alu_sin_decoder: drives serial packets, queues the
// expected decode per packet and compares it on every accepted output.
module tb_alu_sin_decoder;
  import alu_pkg::*;

  localparam int CPB = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } exp_t;

  logic        clk, rst_n, sin, out_ready;
  logic        out_valid, overrun, busy;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_op, out_err;

  exp_t sb[$];
  exp_t mon;
  int   checkCount = 0;
  int   errorCount = 0;

  alu_sin_decoder #(.CLKS_PER_BIT(CPB), .DATA_FRAMES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Every accepted packet must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 64'(out_valid), 64'd0);
      end else begin
        mon = sb.pop_front();
        checkOutput("out_a", 64'(out_a), 64'(mon.a));
        checkOutput("out_b", 64'(out_b), 64'(mon.b));
        checkOutput("out_op", 64'(out_op), 64'(mon.op));
        checkOutput("out_err", 64'(out_err), 64'(mon.err));
      end
    end
  end

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic typ, input logic [7:0] byt, input logic stopBit);
    logic [10:0] bits;
    bits = {1'b0, typ, byt, stopBit};
    for (int i = 10; i >= 0; i--) begin
      sin = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExpect(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic [2:0] err);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.err = err;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] a, input logic [7:0] cmd, input int nData);
    logic [63:0] word;
    word = {b, a};
    for (int i = 0; i < nData; i++) begin
      idle(2);
      sendFrame(DATA_TYPE, word[63-8*i -: 8], 1'b1);
    end
    idle(2);
    sendFrame(CMD_TYPE, cmd, 1'b1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    operation_t  ops[4];
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [7:0]  cmd;
    int          lat;

    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB};
    sin = 1'b1;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_a", 64'(out_a), 64'd0);
    checkOutput("rst_b", 64'(out_b), 64'd0);
    checkOutput("rst_op", 64'(out_op), 64'd0);
    checkOutput("rst_err", 64'(out_err), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    idle(3);

    $display("[TB] clean AND packet and output latency");
    pushExpect(32'h0, 32'h0, 3'b000, 3'b000);
    applyStimulus(32'h0, 32'h0, 8'h0B, 8);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(3 - CPB));
    waitDrain();

    $display("[TB] crc error, op error, clean add");
    pushExpect(32'h0, 32'h0, 3'b000, 3'b010);
    applyStimulus(32'h0, 32'h0, 8'h0C, 8);
    pushExpect(32'h0, 32'h0, 3'b010, 3'b001);
    applyStimulus(32'h0, 32'h0, 8'h2D, 8);
    pushExpect(32'h0, 32'h0, 3'b100, 3'b000);
    applyStimulus(32'h0, 32'h0, 8'h47, 8);
    waitDrain();

    $display("[TB] random operands, all legal opcodes");
    for (int i = 0; i < 4; i++) begin
      b   = $urandom;
      a   = $urandom;
      op  = ops[i];
      cmd = {i[0], op, crc4_calc({b, a, 1'b1, op})};
      pushExpect(a, b, op, 3'b000);
      applyStimulus(b, a, cmd, 8);
    end
    waitDrain();

    $display("[TB] short packet followed by filler command");
    pushExpect(32'h0, 32'h0, 3'b000, 3'b100);
    applyStimulus(32'h11223344, 32'h55667788, 8'h0B, 7);
    idle(2);
    sendFrame(CMD_TYPE, 8'hFF, 1'b1);
    idle(20);
    waitDrain();

    $display("[TB] frame error on third data frame");
    pushExpect(32'h0, 32'h0, 3'b000, 3'b100);
    idle(2);
    sendFrame(DATA_TYPE, 8'hAA, 1'b1);
    idle(2);
    sendFrame(DATA_TYPE, 8'hBB, 1'b1);
    idle(2);
    sendFrame(DATA_TYPE, 8'hCC, 1'b0);
    idle(4);
    checkOutput("busy_after_ferr", 64'(busy), 64'd0);
    waitDrain();
    pushExpect(32'h0, 32'h0, 3'b000, 3'b000);
    applyStimulus(32'h0, 32'h0, 8'h0B, 8);
    waitDrain();

    $display("[TB] overrun while holding, then reset mid-frame");
    out_ready = 1'b0;
    b = 32'hDEADBEEF;
    a = 32'h01234567;
    applyStimulus(b, a, {1'b0, 3'b100, crc4_calc({b, a, 1'b1, 3'b100})}, 8);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("hold_valid", 64'(out_valid), 64'd1);
    checkOutput("hold_overrun_clear", 64'(overrun), 64'd0);
    applyStimulus(32'h0, 32'h0, 8'h0B, 8);
    idle(4);
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    checkOutput("hold_valid2", 64'(out_valid), 64'd1);
    checkOutput("hold_a", 64'(out_a), 64'(a));
    checkOutput("hold_b", 64'(out_b), 64'(b));
    checkOutput("hold_op", 64'(out_op), 64'd4);
    checkOutput("hold_err", 64'(out_err), 64'd0);
    idle(2);
    sin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    sb.delete();
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_a", 64'(out_a), 64'd0);
    checkOutput("mid_rst_b", 64'(out_b), 64'd0);
    checkOutput("mid_rst_err", 64'(out_err), 64'd0);
    checkOutput("mid_rst_overrun", 64'(overrun), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("low_after_rst_busy", 64'(busy), 64'd0);
    checkOutput("low_after_rst_valid", 64'(out_valid), 64'd0);
    idle(3);
    pushExpect(32'h0, 32'h0, 3'b000, 3'b000);
    applyStimulus(32'h0, 32'h0, 8'h0B, 8);
    waitDrain();
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
